// File: rtl/popcount18_combo_gen_pkg.sv
// Shared constants, FSM state type and mask helpers for the popcount18
// combination generator.
package popcount18_pkg;

    localparam int unsigned N_DEF  = 18;
    localparam int unsigned KW     = 5;
    localparam int unsigned IW_DEF = 16;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    // k ones in the lowest bits: the first (smallest) word of a run.
    function automatic logic [N_DEF-1:0] low_mask(input logic [KW-1:0] k);
        logic [N_DEF-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < N_DEF; i++) begin
            if (i < 32'(k)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // k ones in bits n-1..n-k: the last (largest) word of a run.
    function automatic logic [N_DEF-1:0] top_mask(input logic [KW-1:0] k,
                                                  input int unsigned n = N_DEF);
        logic [N_DEF-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < N_DEF; i++) begin
            if ((32'(k) <= n) && (i < n) && (i + 32'(k) >= n)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/popcount18_combo_gen_gosper_next.sv
// Combinational Gosper successor: next larger word with the same popcount.
// Shift by (2 + ctz) replaces the division by the lowest set bit.
module popcount18_gosper_next
    import popcount18_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic [N-1:0] x_i,
    output logic [N-1:0] next_o
);

    logic [N:0] ext;
    logic [N:0] lsb;
    logic [N:0] sum;
    logic [N:0] diff;
    logic [4:0] ctz;
    logic [4:0] shamt;
    logic       found;

    always_comb begin
        ctz   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (x_i[i] && !found) begin
                ctz   = 5'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        ext    = {1'b0, x_i};
        lsb    = ext & (~ext + (N+1)'(1));
        sum    = ext + lsb;
        diff   = ext ^ sum;
        shamt  = ctz + 5'd2;
        // Bit N of the sum is only set past the final word, which never advances.
        next_o = N'(sum | (diff >> shamt));
    end

endmodule

// File: rtl/popcount18_combo_gen.sv
// Emits every N-bit word with exactly k ones, ascending, one per handshake.
// Command in IDLE, stream in RUN, abort or final handshake returns to IDLE.
module popcount18_combo_gen
    import popcount18_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned IW = IW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [KW-1:0] cmd_k,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          err
);

    state_e          state_q;
    logic [N-1:0]    x_q;
    logic [N-1:0]    mask_q;
    logic [IW-1:0]   idx_q;
    logic            last_q;
    logic            err_q;

    logic [N-1:0]    x_next_d;
    logic [N-1:0]    init_x_d;
    logic [N-1:0]    init_mask_d;
    logic [N_DEF-1:0] low_full;
    logic [N_DEF-1:0] top_full;
    logic            k_ok;

    popcount18_gosper_next #(
        .N(N)
    ) u_next (
        .x_i    (x_q),
        .next_o (x_next_d)
    );

    always_comb begin
        low_full    = low_mask(cmd_k);
        top_full    = top_mask(cmd_k, N);
        init_x_d    = low_full[N-1:0];
        init_mask_d = top_full[N-1:0];
        k_ok        = (32'(cmd_k) <= N);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (k_ok) begin
                            state_q <= RUN;
                            x_q     <= init_x_d;
                            mask_q  <= init_mask_d;
                            idx_q   <= '0;
                            last_q  <= (init_x_d == init_mask_d);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Abort wins over any handshake in the same cycle.
                    if (abort) begin
                        state_q <= IDLE;
                        last_q  <= 1'b0;
                    end else if (out_ready) begin
                        if (last_q) begin
                            state_q <= IDLE;
                            last_q  <= 1'b0;
                        end else begin
                            x_q    <= x_next_d;
                            idx_q  <= idx_q + IW'(1);
                            last_q <= (x_next_d == mask_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign out_valid = (state_q == RUN);
    assign out_data  = x_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign err       = err_q;

endmodule
